// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of functional-unit writeback results
// onto NUM_PORTS common-data-bus broadcast ports. Each requester owns a
// one-entry holding register, and selection looks only at the holds. Results
// younger than a mispredicted branch are dropped before they reach a port.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 3,
    parameter int PREG_W    = 7,
    parameter int TAG_W     = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*PREG_W-1:0]   req_preg,
    input  logic [NUM_REQ*TAG_W-1:0]    req_rob_tag,
    input  logic [NUM_REQ-1:0]          req_has_dest,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        mispredict,
    input  logic [TAG_W-1:0]            mispredict_tag,
    input  logic [TAG_W-1:0]            rob_head,
    output logic [NUM_PORTS-1:0]        preg_valid,
    output logic [NUM_PORTS*PREG_W-1:0] preg_rdy,
    output logic [NUM_PORTS-1:0]        rob_cpl_valid,
    output logic [NUM_PORTS*TAG_W-1:0]  rob_cpl_tag
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] hold_v;
    logic [NUM_REQ-1:0] hold_dest;
    logic [PREG_W-1:0]  hold_preg [NUM_REQ];
    logic [TAG_W-1:0]   hold_tag  [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;

    logic [TAG_W-1:0]   mp_age;
    logic [NUM_REQ-1:0] hold_squash;
    logic [NUM_REQ-1:0] in_squash;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_PORTS-1:0] port_used;
    logic [PTR_W-1:0]   port_sel [NUM_PORTS];
    logic               any_grant;
    logic [PTR_W-1:0]   last_grant;

    // A tag is younger than the branch when its distance from the ROB head
    // (modulo ROB depth) is larger than the branch's own distance.
    function automatic logic is_younger(input logic [TAG_W-1:0] tag,
                                        input logic [TAG_W-1:0] head,
                                        input logic [TAG_W-1:0] branch_age);
        logic [TAG_W-1:0] age;
        age = tag - head;
        return age > branch_age;
    endfunction

    // Squash flags for both the held entries and the incoming requests.
    always_comb begin
        mp_age      = mispredict_tag - rob_head;
        hold_squash = '0;
        in_squash   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_squash[i] = mispredict && is_younger(hold_tag[i], rob_head, mp_age);
            in_squash[i]   = mispredict &&
                             is_younger(req_rob_tag[i*TAG_W +: TAG_W], rob_head, mp_age);
        end
    end

    // Round-robin scan from rr_ptr; the j-th surviving hold is placed on port j.
    always_comb begin
        int cnt;
        logic [PTR_W-1:0] idx;
        cnt        = 0;
        idx        = '0;
        grant      = '0;
        port_used  = '0;
        any_grant  = 1'b0;
        last_grant = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            port_sel[j] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (hold_v[idx] && !hold_squash[idx] && cnt < NUM_PORTS) begin
                grant[idx]     = 1'b1;
                port_used[cnt] = 1'b1;
                port_sel[cnt]  = idx;
                any_grant      = 1'b1;
                last_grant     = idx;
                cnt            = cnt + 1;
            end
        end
    end

    // A hold can take a new result when empty or being drained this cycle;
    // forced low while reset is asserted.
    always_comb begin
        req_ready = {NUM_REQ{reset}} & (~hold_v | grant);
        accept    = req_valid & req_ready;
    end

    // Holding registers: load on accept (unless squashed on arrival),
    // otherwise clear when granted or squashed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_v    <= '0;
            hold_dest <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_preg[i] <= '0;
                hold_tag[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i] && !in_squash[i]) begin
                    hold_v[i]    <= 1'b1;
                    hold_dest[i] <= req_has_dest[i];
                    hold_preg[i] <= req_preg[i*PREG_W +: PREG_W];
                    hold_tag[i]  <= req_rob_tag[i*TAG_W +: TAG_W];
                end else if (grant[i] || hold_squash[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves just past the last index granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= PTR_W'((int'(last_grant) + 1) % NUM_REQ);
        end
    end

    // Registered broadcast ports; unused ports carry all zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preg_valid    <= '0;
            preg_rdy      <= '0;
            rob_cpl_valid <= '0;
            rob_cpl_tag   <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (port_used[j]) begin
                    preg_valid[j]                   <= hold_dest[port_sel[j]];
                    preg_rdy[j*PREG_W +: PREG_W]    <= hold_dest[port_sel[j]] ?
                                                       hold_preg[port_sel[j]] : '0;
                    rob_cpl_valid[j]                <= 1'b1;
                    rob_cpl_tag[j*TAG_W +: TAG_W]   <= hold_tag[port_sel[j]];
                end else begin
                    preg_valid[j]                   <= 1'b0;
                    preg_rdy[j*PREG_W +: PREG_W]    <= '0;
                    rob_cpl_valid[j]                <= 1'b0;
                    rob_cpl_tag[j*TAG_W +: TAG_W]   <= '0;
                end
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates functional-unit writeback requests (ALU, branch, LSU, extra units) onto the NUM_PORTS common-data-bus broadcast ports. These ports feed the dispatch/RS wakeup inputs (preg1..3_valid/rdy) and the ROB completion path. Each requester has a one-entry holding register, and grants are round-robin. Wrong-path results younger than a mispredicted branch are squashed before broadcast.

## Interface
- NUM_REQ, 4, number of writeback requesters
- NUM_PORTS, 3, number of CDB broadcast ports
- PREG_W, 7, physical register tag width
- TAG_W, 5, ROB tag width; ROB depth = 2^TAG_W
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req_valid  in  NUM_REQ  requester i has a result
- req_preg  in  NUM_REQ*PREG_W  destination preg, slice i
- req_rob_tag  in  NUM_REQ*TAG_W  ROB tag, slice i
- req_has_dest  in  NUM_REQ  1 = writes a preg; 0 = completion only (branch, store)
- req_ready  out  NUM_REQ  holding register i can accept this cycle
- mispredict  in  1  branch mispredict this cycle
- mispredict_tag  in  TAG_W  ROB tag of the mispredicted branch
- rob_head  in  TAG_W  oldest in-flight ROB tag, used for age comparison
- preg_valid  out  NUM_PORTS  port k broadcasts a wakeup
- preg_rdy  out  NUM_PORTS*PREG_W  preg broadcast on port k
- rob_cpl_valid  out  NUM_PORTS  port k completes a ROB entry
- rob_cpl_tag  out  NUM_PORTS*TAG_W  ROB tag completed on port k

## Operation
- State:
  - hold_v, hold_preg, hold_tag and hold_dest per requester
  - rr_ptr, $clog2(NUM_REQ) bits
  - registered output ports
- Accept: a transfer happens when req_valid[i] && req_ready[i]. It loads hold i at the edge.
- req_ready[i] = !hold_v[i] || grant[i]. This is combinational and independent of mispredict and of req_valid.
- Select (combinational, from holds only, no bypass of incoming requests):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Grant the first NUM_PORTS entries that are valid and not squashed.
  - The j-th grant in scan order drives port j. Ports with no grant output valid = 0.
- Port load for a grant on port j:
  - preg_valid[j] = hold_dest
  - preg_rdy[j] = hold_preg if hold_dest, else 0
  - rob_cpl_valid[j] = 1
  - rob_cpl_tag[j] = hold_tag
- Non-granted ports load all zeros.
- A granted hold clears at the edge, unless a new request is accepted into it in the same cycle; in that case it reloads.
- rr_ptr: becomes (last granted index + 1) mod NUM_REQ. It is unchanged when nothing is granted.
- Squash:
  - Age of tag t = (t − rob_head) mod 2^TAG_W, computed in TAG_W-bit unsigned wraparound arithmetic.
  - Tag t is younger iff age(t) > age(mispredict_tag).
  - While mispredict = 1:
    - A hold with a younger tag is not granted and is cleared at the edge.
    - An incoming accepted request with a younger tag is discarded. It still handshakes (ready as normal) and does not load.
  - The mispredicted branch itself and all older tags proceed normally.
  - Outputs already registered (visible this cycle) are never retracted.
- Equal tags in different holds are not checked; upstream guarantees unique tags.

## Timing
- Reset values, while reset = 0: all hold_v = 0, rr_ptr = 0, and every output bit 0. req_ready also reads 0 during reset.
- Latency:
  - A request accepted at edge E is eligible in the next cycle.
  - If granted, it is broadcast in the cycle after edge E+1 (2 cycles from req_valid to preg_valid).
- Each broadcast lasts exactly 1 cycle. There is no backpressure on the CDB.
- Throughput:
  - Each requester sustains 1 result per cycle while it is granted every cycle.
  - Worst-case wait for a held entry is ceil(NUM_REQ/NUM_PORTS) cycles (2 for the defaults).
- Full: when hold i is valid and not granted, req_ready[i] = 0. The requester holds its data until ready.
- Simultaneous mispredict and grant: the squash filter is applied before selection, so a younger entry never reaches a port.
- Reset mid-operation: held results are lost, outputs drop within the reset assertion, and nothing stale is broadcast after release.

## Test plan
- Single request:
  - Stimulus: req0, preg 10, tag 1, has_dest 1, in cycle 0.
  - Response: cycle 2 shows preg_valid = 3'b001, port0 preg = 10, rob_cpl_tag port0 = 1. Cycle 3 shows all outputs 0.
- Four-way contention:
  - Stimulus: req0..3 (pregs 20..23) in the same cycle with rr_ptr = 0.
  - Response: the first broadcast cycle carries ports 0..2 = 20, 21, 22. req_ready[3] = 0 in the selection cycle. The next cycle carries port0 = 23.
  - rr_ptr sequence: 3, then 0.
- Completion only:
  - Stimulus: req1 with has_dest 0, tag 7.
  - Response: preg_valid[0] = 0, preg_rdy port0 = 0, rob_cpl_valid[0] = 1, tag 7.
- Squash:
  - Stimulus: rob_head = 0; holds contain tags 3, 5 and 9; mispredict with tag 5.
  - Response: tags 3 and 5 broadcast; tag 9 never appears and its hold clears.
- Wraparound squash:
  - Stimulus: rob_head = 30; holds contain tags 30 and 0; mispredict_tag = 31.
  - Response: tag 30 broadcast; tag 0 is squashed.
- Async reset:
  - Stimulus: reset asserted mid-cycle with all holds full.
  - Response: all outputs 0 immediately, without waiting for an edge. After release, no broadcast occurs until new requests arrive, and rr_ptr = 0.
